prog_mem_responder: RTL and testbench

- Responder end of the core's instruction-fetch req/gnt interface: accepts fetch requests from the program counter and returns instruction words.
- Holds a word-addressed program RAM with a separate loader write port used by the testbench and boot logic.
- Configurable wait states model slower program memory, so core stall and hold-on-no-grant behaviour can be exercised.
- At most one request outstanding, with back-to-back acceptance in the response cycle.

---
 rtl/prog_mem_responder_pkg.sv | 15 +
 rtl/prog_mem_array.sv | 51 +++++
 rtl/prog_mem_responder.sv | 157 +++++++++++++++
 tb/tb_prog_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_responder_pkg.sv
// Shared types and constants for the program-memory responder.
package prog_mem_responder_pkg;

   localparam int unsigned REG_DATA_WIDTH_DEF = 32;
   localparam int unsigned CNT_W              = 4;

   localparam logic [REG_DATA_WIDTH_DEF-1:0] RST_DATA = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/prog_mem_array.sv
// Word-addressed program RAM: one synchronous write port, one registered
// read port. A same-edge write to the word being read returns the old data.
module prog_mem_array
   import prog_mem_responder_pkg::*;
#(
   parameter int unsigned DW    = REG_DATA_WIDTH_DEF,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic          rzero_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   // Storage write; contents survive reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data select: hold unless reading; an error read forces zero.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = rzero_i ? DW'(RST_DATA) : mem_q[raddr_i];
      end
   end

   // Output data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= DW'(RST_DATA);
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_responder.sv
// Instruction-fetch responder: req/gnt front end, wait-state FSM and program
// RAM with a loader write port. Optional macro PROG_MEM_ERR_EN adds err_o for
// misaligned or out-of-range fetches.
module prog_mem_responder
   import prog_mem_responder_pkg::*;
#(
   parameter int unsigned REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
   parameter int unsigned MEM_DEPTH      = 1024,
   parameter int unsigned WAIT_CYCLES    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_mem_prog_i,
   input  logic [REG_DATA_WIDTH-1:0] addr_i,
   output logic                      gnt_mem_prog_o,
   output logic                      rvalid_o,
   output logic [REG_DATA_WIDTH-1:0] rdata_o,
   input  logic                      ld_we_i,
   input  logic [REG_DATA_WIDTH-1:0] ld_addr_i,
   input  logic [REG_DATA_WIDTH-1:0] ld_wdata_i
`ifdef PROG_MEM_ERR_EN
   ,
   output logic                      err_o
`endif
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             rvalid_q, rvalid_d;
   logic             gnt_c;
   logic             rd_en_c;
   logic             rzero_c;

   // Grant is combinational so the requester can hold its PC in the same cycle.
   assign gnt_c = req_mem_prog_i & ((state_q == IDLE) | (state_q == RESP)) & ~rst;
   assign gnt_mem_prog_o = gnt_c;

`ifdef PROG_MEM_ERR_EN
   logic err_lat_q, err_lat_d;
   logic err_q, err_d;
   logic addr_err_c;

   // Misaligned or beyond the RAM footprint.
   assign addr_err_c = (addr_i[1:0] != 2'b00) ||
                       (addr_i >= REG_DATA_WIDTH'(MEM_DEPTH * 4));
`endif

   // Next state, wait counter and address latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
`ifdef PROG_MEM_ERR_EN
      err_lat_d = err_lat_q;
`endif
      case (state_q)
         IDLE: ;
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (gnt_c) begin
         idx_d = addr_i[AW+1:2];
`ifdef PROG_MEM_ERR_EN
         err_lat_d = addr_err_c;
`endif
         if (WAIT_CYCLES == 0) begin
            state_d = RESP;
         end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
         end
      end
   end

   // The RAM is read on the edge that enters RESP.
   assign rd_en_c  = (state_d == RESP) & ~rst;
   assign rvalid_d = rd_en_c;

`ifdef PROG_MEM_ERR_EN
   assign rzero_c = err_lat_d;

   // Error flag published alongside the response.
   always_comb begin
      err_d = err_q;
      if (rd_en_c) begin
         err_d = err_lat_d;
      end
   end
`else
   assign rzero_c = 1'b0;
`endif

   // State and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         rvalid_q <= 1'b0;
`ifdef PROG_MEM_ERR_EN
         err_lat_q <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rvalid_q <= rvalid_d;
`ifdef PROG_MEM_ERR_EN
         err_lat_q <= err_lat_d;
         err_q     <= err_d;
`endif
      end
   end

   assign rvalid_o = rvalid_q;
`ifdef PROG_MEM_ERR_EN
   assign err_o = err_q;
`endif

   prog_mem_array #(
      .DW    (REG_DATA_WIDTH),
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ld_we_i),
      .waddr_i (ld_addr_i[AW+1:2]),
      .wdata_i (ld_wdata_i),
      .re_i    (rd_en_c),
      .rzero_i (rzero_c),
      .raddr_i (idx_d),
      .rdata_o (rdata_o)
   );

   // Address bits outside the word index are don't-care.
`ifdef PROG_MEM_ERR_EN
   logic unused_c;
   assign unused_c = ^{ld_addr_i[REG_DATA_WIDTH-1:AW+2], ld_addr_i[1:0]};
`else
   logic unused_c;
   assign unused_c = ^{ld_addr_i[REG_DATA_WIDTH-1:AW+2], ld_addr_i[1:0],
                       addr_i[REG_DATA_WIDTH-1:AW+2], addr_i[1:0]};
`endif

endmodule

// File: tb/tb_prog_mem_responder.sv
// Bench for prog_mem_responder: two instances (0 and 3 wait states) share the
// loader and reset; a reference model predicts grants and responses, a
// negedge monitor compares them.
module tb_prog_mem_responder;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WC0   = 0;
   localparam int unsigned WC1   = 3;

   logic          clk;
   logic          rst;
   logic [1:0]    req;
   logic [31:0]   addr [2];
   logic [1:0]    gnt;
   logic [1:0]    rvalid;
   logic [31:0]   rdata [2];
   logic [1:0]    err;
   logic          ld_we;
   logic [31:0]   ld_addr;
   logic [31:0]   ld_wdata;

   prog_mem_responder #(.REG_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC0)) u_dut0 (
      .clk(clk), .rst(rst), .req_mem_prog_i(req[0]), .addr_i(addr[0]),
      .gnt_mem_prog_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata)
`ifdef PROG_MEM_ERR_EN
      , .err_o(err[0])
`endif
   );

   prog_mem_responder #(.REG_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC1)) u_dut1 (
      .clk(clk), .rst(rst), .req_mem_prog_i(req[1]), .addr_i(addr[1]),
      .gnt_mem_prog_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata)
`ifdef PROG_MEM_ERR_EN
      , .err_o(err[1])
`endif
   );

`ifndef PROG_MEM_ERR_EN
   assign err = 2'b00;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int          inst;
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mem_m [DEPTH];
   int          cyc = 0;
   int          busy_until [2] = '{0, 0};
   bit          pend_v [2] = '{0, 0};
   int          pend_rc [2];
   logic [31:0] pend_addr [2];
   logic [31:0] last_data [2] = '{32'h0, 32'h0};
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic int wc_of(input int i);
      return (i == 0) ? int'(WC0) : int'(WC1);
   endfunction

   function automatic logic addr_err(input logic [31:0] a);
`ifdef PROG_MEM_ERR_EN
      return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
      return 1'b0;
`endif
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'(a / 4) % int'(DEPTH);
   endfunction

   // Model: an accepted fetch is answered WAIT+1 cycles later with the word
   // as stored before the edge that reads it; reset cancels what is in flight.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            pend_v[i]     = 0;
            busy_until[i] = 0;
            for (int k = sb.size() - 1; k >= 0; k--)
               if (sb[k].inst == i && sb[k].due > cyc) sb.delete(k);
         end else begin
            if (req[i] && busy_until[i] <= cyc) begin
               pend_v[i]     = 1;
               pend_addr[i]  = addr[i];
               pend_rc[i]    = cyc + wc_of(i);
               busy_until[i] = cyc + wc_of(i) + 1;
            end
            if (pend_v[i] && pend_rc[i] == cyc) begin
               exp_t e;
               e.inst = i;
               e.err  = addr_err(pend_addr[i]);
               e.data = e.err ? 32'h0 : mem_m[word_of(pend_addr[i])];
               e.due  = cyc + 1;
               sb.push_back(e);
               pend_v[i] = 0;
            end
         end
      end
      if (ld_we) mem_m[word_of(ld_addr)] = ld_wdata;
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic g_exp;
      int   h;
      for (int i = 0; i < 2; i++) begin
         g_exp = req[i] && !rst && (busy_until[i] <= cyc);
         chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(g_exp));
         h = -1;
         for (int k = 0; k < sb.size(); k++)
            if (h < 0 && sb[k].inst == i) h = k;
         if (h >= 0 && sb[h].due == cyc) begin
            chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'd1);
            chk($sformatf("rdata%0d", i), rdata[i], sb[h].data);
`ifdef PROG_MEM_ERR_EN
            chk($sformatf("err%0d", i), 32'(err[i]), 32'(sb[h].err));
`endif
            last_data[i] = sb[h].data;
            sb.delete(h);
         end else begin
            chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'd0);
            chk($sformatf("rdata_hold%0d", i), rdata[i], last_data[i]);
         end
         if (rst) last_data[i] = 32'h0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req = 2'b00;
      repeat (n) tick();
   endtask

   task automatic fetch(input logic [1:0] r, input logic [31:0] a);
      req     = r;
      addr[0] = a;
      addr[1] = a;
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      req      = 2'b11;
      addr[0]  = 32'h0;
      addr[1]  = 32'h0;
      ld_we    = 1'b0;
      ld_addr  = 32'h0;
      ld_wdata = 32'h0;
      repeat (3) tick();
      rst = 1'b0;
      req = 2'b00;

      // Preload the whole RAM, with known words at the directed addresses.
      for (int w = 0; w < int'(DEPTH); w++) begin
         ld_we   = 1'b1;
         ld_addr = 32'(w) << 2;
         case (w)
            0:       ld_wdata = 32'h0000_0013;
            1:       ld_wdata = 32'h0010_0093;
            2:       ld_wdata = 32'hDEAD_BEEF;
            4:       ld_wdata = 32'h1111_1111;
            default: ld_wdata = $urandom;
         endcase
         tick();
      end
      ld_we = 1'b0;

      // Back-to-back fetches of 0x0 then 0x4.
      fetch(2'b11, 32'h0);
      fetch(2'b11, 32'h4);
      idle(8);

      // Request held through the wait states of the slow instance.
      repeat (5) fetch(2'b10, 32'h8);
      idle(8);

      // Reset one cycle after grant; then a fresh fetch from IDLE.
      fetch(2'b10, 32'h8);
      rst = 1'b1;
      fetch(2'b00, 32'h8);
      rst = 1'b0;
      fetch(2'b10, 32'h8);
      idle(8);

      // Loader write on the edge that reads the same word.
      ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'h2222_2222;
      fetch(2'b01, 32'h10);
      ld_we = 1'b0;
      fetch(2'b01, 32'h10);
      idle(4);
      // Same conflict on the slow instance: write lands on its RESP-entry edge.
      ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'h1111_1111;
      tick(); ld_we = 1'b0;
      fetch(2'b10, 32'h10);
      idle(2);
      ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'h3333_3333;
      tick(); ld_we = 1'b0;
      idle(6);
      fetch(2'b10, 32'h10);
      idle(6);

      // Wrap-around / error addresses.
      fetch(2'b11, 32'h1004);
      idle(6);
      fetch(2'b01, 32'h2);
      fetch(2'b01, 32'h1000);
      fetch(2'b01, 32'h4);
      idle(6);

      // Randomised traffic with loader writes and occasional reset.
      for (int n = 0; n < 600; n++) begin
         req = 2'($urandom);
         for (int i = 0; i < 2; i++)
            addr[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                  : 32'($urandom_range(0, DEPTH - 1)) << 2;
         ld_we    = ($urandom_range(0, 2) == 0);
         ld_addr  = ($urandom_range(0, 1) == 0) ? 32'($urandom) : addr[$urandom_range(0, 1)];
         ld_wdata = $urandom;
         rst      = ($urandom_range(0, 59) == 0);
         tick();
      end
      rst   = 1'b0;
      ld_we = 1'b0;
      idle(10);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
